mod_exp_engine: RTL



---
 rtl/mod_exp_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mod_exp_engine.sv
// Modular exponentiator: res = base^exp mod m, right-to-left square-and-multiply.
// Every modular product comes from one shared bit-serial interleaved multiplier.
// That multiplier takes N cycles per product and needs no wide multiplier or divider.
// The modulus is a runtime input. The handshake is busy/done/err, and abort and ena are supported.
module mod_exp_engine #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] base,
    input  logic [N-1:0] exp,
    input  logic [N-1:0] mod,
    output logic [N-1:0] res,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_CHECK,
        S_MULR,
        S_SQR,
        S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [N-1:0]   base_r;
    logic [N-1:0]   exp_r;
    logic [N-1:0]   mod_r;
    logic [N-1:0]   res_acc;
    logic [N-1:0]   acc;
    logic [CW-1:0]  cnt;
    logic           err_flag;

    logic           in_mul;
    logic           mul_last;
    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic [N-1:0]   mul_res;

    // One interleaved step: acc' = (2*acc + b_bit*a) mod m, for acc < m and a < m.
    // The intermediate value stays below 2m, so N+1 bits are enough.
    function automatic logic [N-1:0] mod_step(input logic [N-1:0] acc_in,
                                              input logic [N-1:0] a_in,
                                              input logic         b_bit,
                                              input logic [N-1:0] m_in);
        logic [N:0] mw;
        logic [N:0] t;
        mw = {1'b0, m_in};
        t  = {acc_in, 1'b0};
        if (t >= mw) t = t - mw;
        if (b_bit)   t = t + {1'b0, a_in};
        return (t >= mw) ? N'(t - mw) : N'(t);
    endfunction

    // Operand routing for the shared multiplier.
    // REDUCE computes 1*base, MULR computes base_r*res_acc, and SQR computes base_r*base_r.
    always_comb begin
        in_mul   = (state == S_REDUCE) || (state == S_MULR) || (state == S_SQR);
        mul_last = in_mul && (cnt == '0);
        mul_a    = (state == S_REDUCE) ? N'(1) : base_r;
        mul_b    = (state == S_MULR) ? res_acc : base_r;
        mul_res  = mod_step(acc, mul_a, mul_b[cnt], mod_r);
    end

    // Next-state logic; abort in any active state returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start && !abort) state_nx = S_LOAD;
            // A bad modulus takes the CHECK path with exp forced to 0.
            S_LOAD:   state_nx = (mod_r < N'(2)) ? S_CHECK : S_REDUCE;
            S_REDUCE: if (mul_last) state_nx = S_CHECK;
            S_CHECK: begin
                if (exp_r == '0)   state_nx = S_DONE;
                else if (exp_r[0]) state_nx = S_MULR;
                else               state_nx = S_SQR;
            end
            S_MULR:   if (mul_last) state_nx = S_SQR;
            S_SQR:    if (mul_last) state_nx = S_CHECK;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nx = S_IDLE;
    end

    // State, operand registers, multiplier accumulator/counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            base_r   <= '0;
            exp_r    <= '0;
            mod_r    <= '0;
            res_acc  <= '0;
            acc      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            res      <= '0;
            err      <= 1'b0;
        end else if (ena) begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        base_r   <= base;
                        exp_r    <= exp;
                        mod_r    <= mod;
                        err_flag <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (mod_r < N'(2)) begin
                        err_flag <= 1'b1;
                        res_acc  <= '0;
                        exp_r    <= '0;
                    end else begin
                        res_acc  <= N'(1);
                    end
                end
                S_REDUCE: if (mul_last) base_r <= mul_res;
                S_MULR:   if (mul_last) res_acc <= mul_res;
                S_SQR: begin
                    if (mul_last) begin
                        base_r <= mul_res;
                        exp_r  <= exp_r >> 1;
                    end
                end
                default: ;
            endcase
            // The accumulator and counter re-arm whenever no product is in progress.
            // That way every multiply state starts from acc=0 and cnt=N-1.
            if (in_mul && !mul_last) begin
                cnt <= cnt - 1'b1;
                acc <= mul_res;
            end else begin
                cnt <= CW'(N - 1);
                acc <= '0;
            end
            // The result is published on the edge entering DONE, so it is valid with done.
            if ((state_nx == S_DONE) && (state != S_DONE)) begin
                res <= res_acc;
                err <= err_flag;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
